// File: rtl/lamp_ramp_sequencer.sv
// Steps a thermometer-coded lamp bank and a shade motor toward a requested target,
// one step per dwell period (lamps first, then shade) to limit inrush and motor slam.
module lamp_ramp_sequencer #(
    parameter int LAMPS       = 15,
    parameter int STEP_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_lightnum,
    input  logic [3:0]       req_wshade,
    output logic [LAMPS-1:0] lamp_on,
    output logic [3:0]       shade_pos,
    output logic             shade_step_up,
    output logic             shade_step_dn,
    output logic             busy,
    output logic             done
);

    localparam int               CW         = $clog2(LAMPS + 1);
    localparam logic [CW-1:0]    LAMPS_C    = CW'(LAMPS);
    localparam logic [CW-1:0]    CNT_ONE    = CW'(32'd1);
    localparam logic [7:0]       DWELL_LAST = 8'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r;
    logic [7:0]        dwell_r;
    logic [CW-1:0]     lamp_cnt_r;
    logic [CW-1:0]     tgt_l_r;
    logic [3:0]        tgt_s_r;
    logic [3:0]        shade_pos_r;
    logic [LAMPS-1:0]  lamp_on_r;
    logic              step_up_r;
    logic              step_dn_r;
    logic              busy_r;
    logic              done_r;
    logic              lamp_match_s;
    logic              shade_match_s;

    // Lamp k is lit iff k < cnt, so ramp-down always drops the highest lamp first.
    function automatic logic [LAMPS-1:0] therm_f(input logic [CW-1:0] cnt);
        logic [LAMPS-1:0] v;
        v = {LAMPS{1'b0}};
        for (int k = 0; k < LAMPS; k++) begin
            v[k] = (k < int'(cnt));
        end
        return v;
    endfunction

    assign lamp_match_s  = (lamp_cnt_r == tgt_l_r);
    assign shade_match_s = (shade_pos_r == tgt_s_r);
    assign req_ready     = (state_r == IDLE);

    assign lamp_on       = lamp_on_r;
    assign shade_pos     = shade_pos_r;
    assign shade_step_up = step_up_r;
    assign shade_step_dn = step_dn_r;
    assign busy          = busy_r;
    assign done          = done_r;

    // Sequencer FSM: accept target, step once per dwell period, pulse done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            dwell_r     <= 8'd0;
            lamp_cnt_r  <= {CW{1'b0}};
            tgt_l_r     <= {CW{1'b0}};
            tgt_s_r     <= 4'd0;
            shade_pos_r <= 4'd0;
            lamp_on_r   <= {LAMPS{1'b0}};
            step_up_r   <= 1'b0;
            step_dn_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            step_up_r <= 1'b0;
            step_dn_r <= 1'b0;
            done_r    <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        if (int'(req_lightnum) > LAMPS) begin
                            tgt_l_r <= LAMPS_C;
                        end else begin
                            tgt_l_r <= CW'(req_lightnum);
                        end
                        tgt_s_r <= req_wshade;
                        dwell_r <= 8'd0;
                        busy_r  <= 1'b1;
                        state_r <= RAMP;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                RAMP: begin
                    if (lamp_match_s && shade_match_s) begin
                        dwell_r <= 8'd0;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else if (dwell_r == DWELL_LAST) begin
                        dwell_r <= 8'd0;
                        // Lamps take priority; the shade only moves once lamps are on target.
                        if (!lamp_match_s) begin
                            if (lamp_cnt_r < tgt_l_r) begin
                                lamp_cnt_r <= lamp_cnt_r + CNT_ONE;
                                lamp_on_r  <= therm_f(lamp_cnt_r + CNT_ONE);
                            end else begin
                                lamp_cnt_r <= lamp_cnt_r - CNT_ONE;
                                lamp_on_r  <= therm_f(lamp_cnt_r - CNT_ONE);
                            end
                        end else if (shade_pos_r < tgt_s_r) begin
                            shade_pos_r <= shade_pos_r + 4'd1;
                            step_up_r   <= 1'b1;
                        end else begin
                            shade_pos_r <= shade_pos_r - 4'd1;
                            step_dn_r   <= 1'b1;
                        end
                    end else begin
                        dwell_r <= dwell_r + 8'd1;
                    end
                end
                DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    dwell_r <= 8'd0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lamp_ramp_sequencer.sv
// Table-driven bench for lamp_ramp_sequencer (LAMPS=15, STEP_CYCLES=4), plus a
// hand-written clamp sequence on a LAMPS=8, STEP_CYCLES=1 instance.
module tb_lamp_ramp_sequencer;

    // Input controls {rst, valid}
    localparam logic [1:0] NOP = 2'b00;
    localparam logic [1:0] VLD = 2'b01;
    localparam logic [1:0] RST = 2'b10;
    // Expected {req_ready, busy, done}
    localparam logic [2:0] S_IDLE = 3'b100;
    localparam logic [2:0] S_BUSY = 3'b010;
    localparam logic [2:0] S_DONE = 3'b011;
    // Expected {shade_step_up, shade_step_dn}
    localparam logic [1:0] P_NO = 2'b00;
    localparam logic [1:0] P_UP = 2'b10;
    localparam logic [1:0] P_DN = 2'b01;

    typedef struct {
        logic [1:0]  ctl;
        logic [3:0]  ln;
        logic [3:0]  ws;
        logic [2:0]  st;
        logic [14:0] lamp;
        logic [3:0]  sh;
        logic [1:0]  pul;
    } vec_t;

    vec_t vecs[$];

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_lightnum;
    logic [3:0]  req_wshade;
    logic [14:0] lamp_on;
    logic [3:0]  shade_pos;
    logic        shade_step_up;
    logic        shade_step_dn;
    logic        busy;
    logic        done;

    logic        v2;
    logic        rdy2;
    logic [3:0]  ln2;
    logic [3:0]  ws2;
    logic [7:0]  lamp2;
    logic [3:0]  shade2;
    logic        up2;
    logic        dn2;
    logic        busy2;
    logic        done2;

    int n_vec;
    int n_bad;

    always #5 clk = ~clk;

    lamp_ramp_sequencer #(.LAMPS(15), .STEP_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_lightnum(req_lightnum), .req_wshade(req_wshade), .lamp_on(lamp_on),
        .shade_pos(shade_pos), .shade_step_up(shade_step_up),
        .shade_step_dn(shade_step_dn), .busy(busy), .done(done)
    );

    lamp_ramp_sequencer #(.LAMPS(8), .STEP_CYCLES(1)) dut8 (
        .clk(clk), .rst(rst), .req_valid(v2), .req_ready(rdy2),
        .req_lightnum(ln2), .req_wshade(ws2), .lamp_on(lamp2),
        .shade_pos(shade2), .shade_step_up(up2),
        .shade_step_dn(dn2), .busy(busy2), .done(done2)
    );

    task automatic push(input int n, input logic [1:0] ctl, input logic [3:0] ln,
                        input logic [3:0] ws, input logic [2:0] st,
                        input logic [14:0] lamp, input logic [3:0] sh,
                        input logic [1:0] pul);
        vec_t t;
        t.ctl = ctl; t.ln = ln; t.ws = ws; t.st = st;
        t.lamp = lamp; t.sh = sh; t.pul = pul;
        for (int i = 0; i < n; i++) vecs.push_back(t);
    endtask

    initial begin
        bit got;
        int dcyc;
        rst = 1'b1; req_valid = 1'b0; req_lightnum = 4'd0; req_wshade = 4'd0;
        v2 = 1'b0; ln2 = 4'd0; ws2 = 4'd0;
        n_vec = 0; n_bad = 0;

        // Reset and idle
        push(2, RST, 4'd0, 4'd0, S_IDLE, 15'h0000, 4'd0, P_NO);
        push(2, NOP, 4'd0, 4'd0, S_IDLE, 15'h0000, 4'd0, P_NO);
        // Ramp up to 3 lamps
        push(1, VLD, 4'd3, 4'd0, S_BUSY, 15'h0000, 4'd0, P_NO);
        push(3, NOP, 4'd3, 4'd0, S_BUSY, 15'h0000, 4'd0, P_NO);
        push(4, NOP, 4'd3, 4'd0, S_BUSY, 15'h0001, 4'd0, P_NO);
        push(4, NOP, 4'd3, 4'd0, S_BUSY, 15'h0003, 4'd0, P_NO);
        push(1, NOP, 4'd3, 4'd0, S_BUSY, 15'h0007, 4'd0, P_NO);
        push(1, NOP, 4'd3, 4'd0, S_DONE, 15'h0007, 4'd0, P_NO);
        push(1, NOP, 4'd3, 4'd0, S_IDLE, 15'h0007, 4'd0, P_NO);
        // Lamps down to 1, then shade up to 2
        push(1, VLD, 4'd1, 4'd2, S_BUSY, 15'h0007, 4'd0, P_NO);
        push(3, NOP, 4'd1, 4'd2, S_BUSY, 15'h0007, 4'd0, P_NO);
        push(4, NOP, 4'd1, 4'd2, S_BUSY, 15'h0003, 4'd0, P_NO);
        push(4, NOP, 4'd1, 4'd2, S_BUSY, 15'h0001, 4'd0, P_NO);
        push(1, NOP, 4'd1, 4'd2, S_BUSY, 15'h0001, 4'd1, P_UP);
        push(3, NOP, 4'd1, 4'd2, S_BUSY, 15'h0001, 4'd1, P_NO);
        push(1, NOP, 4'd1, 4'd2, S_BUSY, 15'h0001, 4'd2, P_UP);
        push(1, NOP, 4'd1, 4'd2, S_DONE, 15'h0001, 4'd2, P_NO);
        push(1, NOP, 4'd1, 4'd2, S_IDLE, 15'h0001, 4'd2, P_NO);
        // Target equal to current state
        push(1, VLD, 4'd1, 4'd2, S_BUSY, 15'h0001, 4'd2, P_NO);
        push(1, NOP, 4'd1, 4'd2, S_DONE, 15'h0001, 4'd2, P_NO);
        push(1, NOP, 4'd1, 4'd2, S_IDLE, 15'h0001, 4'd2, P_NO);
        // Request to 2 lamps; a second request (0,0) is held valid during the ramp
        push(1, VLD, 4'd2, 4'd2, S_BUSY, 15'h0001, 4'd2, P_NO);
        push(3, VLD, 4'd0, 4'd0, S_BUSY, 15'h0001, 4'd2, P_NO);
        push(1, VLD, 4'd0, 4'd0, S_BUSY, 15'h0003, 4'd2, P_NO);
        push(1, VLD, 4'd0, 4'd0, S_DONE, 15'h0003, 4'd2, P_NO);
        push(1, VLD, 4'd0, 4'd0, S_IDLE, 15'h0003, 4'd2, P_NO);
        push(1, VLD, 4'd0, 4'd0, S_BUSY, 15'h0003, 4'd2, P_NO);
        push(3, NOP, 4'd0, 4'd0, S_BUSY, 15'h0003, 4'd2, P_NO);
        push(4, NOP, 4'd0, 4'd0, S_BUSY, 15'h0001, 4'd2, P_NO);
        push(4, NOP, 4'd0, 4'd0, S_BUSY, 15'h0000, 4'd2, P_NO);
        push(1, NOP, 4'd0, 4'd0, S_BUSY, 15'h0000, 4'd1, P_DN);
        push(3, NOP, 4'd0, 4'd0, S_BUSY, 15'h0000, 4'd1, P_NO);
        push(1, NOP, 4'd0, 4'd0, S_BUSY, 15'h0000, 4'd0, P_DN);
        push(1, NOP, 4'd0, 4'd0, S_DONE, 15'h0000, 4'd0, P_NO);
        push(1, NOP, 4'd0, 4'd0, S_IDLE, 15'h0000, 4'd0, P_NO);
        // Ramp toward 9 lamps, reset once 5 are lit
        push(1, VLD, 4'd9, 4'd3, S_BUSY, 15'h0000, 4'd0, P_NO);
        push(3, NOP, 4'd9, 4'd3, S_BUSY, 15'h0000, 4'd0, P_NO);
        push(4, NOP, 4'd9, 4'd3, S_BUSY, 15'h0001, 4'd0, P_NO);
        push(4, NOP, 4'd9, 4'd3, S_BUSY, 15'h0003, 4'd0, P_NO);
        push(4, NOP, 4'd9, 4'd3, S_BUSY, 15'h0007, 4'd0, P_NO);
        push(4, NOP, 4'd9, 4'd3, S_BUSY, 15'h000F, 4'd0, P_NO);
        push(1, NOP, 4'd9, 4'd3, S_BUSY, 15'h001F, 4'd0, P_NO);
        push(1, RST, 4'd9, 4'd3, S_IDLE, 15'h0000, 4'd0, P_NO);
        push(2, NOP, 4'd9, 4'd3, S_IDLE, 15'h0000, 4'd0, P_NO);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst          = vecs[i].ctl[1];
            req_valid    = vecs[i].ctl[0];
            req_lightnum = vecs[i].ln;
            req_wshade   = vecs[i].ws;
            @(posedge clk);
            #1;
            n_vec++;
            if ({req_ready, busy, done} !== vecs[i].st || lamp_on !== vecs[i].lamp ||
                shade_pos !== vecs[i].sh || {shade_step_up, shade_step_dn} !== vecs[i].pul) begin
                n_bad++;
                $display("FAIL vec%0d: got rdy/busy/done=%b lamp_on=%h shade=%0d up/dn=%b, want %b %h %0d %b",
                         i, {req_ready, busy, done}, lamp_on, shade_pos,
                         {shade_step_up, shade_step_dn}, vecs[i].st, vecs[i].lamp,
                         vecs[i].sh, vecs[i].pul);
            end
        end

        // Clamp: lightnum 15 on an 8-lamp bank, one step per cycle
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        v2 = 1'b1; ln2 = 4'd15; ws2 = 4'd0;
        @(posedge clk);
        #1;
        n_vec++;
        if (rdy2 !== 1'b0 || busy2 !== 1'b1) begin
            n_bad++;
            $display("FAIL clamp_accept: got rdy=%b busy=%b, want 0 1", rdy2, busy2);
        end
        @(negedge clk);
        v2 = 1'b0;
        got = 1'b0;
        dcyc = 0;
        for (int c = 1; c <= 30 && !got; c++) begin
            @(posedge clk);
            #1;
            if (done2 === 1'b1) begin
                got = 1'b1;
                dcyc = c;
            end
        end
        n_vec++;
        if (!got || dcyc != 9 || lamp2 !== 8'hFF || shade2 !== 4'd0) begin
            n_bad++;
            $display("FAIL clamp_done: got done_seen=%0d at edge %0d lamp_on=%h shade=%0d, want 1 at edge 9 lamp_on=ff shade=0",
                     got, dcyc, lamp2, shade2);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (rdy2 !== 1'b1 || busy2 !== 1'b0 || done2 !== 1'b0 || lamp2 !== 8'hFF) begin
            n_bad++;
            $display("FAIL clamp_idle: got rdy=%b busy=%b done=%b lamp_on=%h, want 1 0 0 ff",
                     rdy2, busy2, done2, lamp2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
